// File: rtl/arp_hdr_rewrite.sv
// ARP result consumer: holds a routed packet's first beat until its ARP result
// arrives, rewrites MACs/TTL/checksum/output port, then streams the body through.
module arp_hdr_rewrite #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int RES_DEPTH_BITS       = 2
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              arp_done,
  input  logic                              arp_hit,
  input  logic [47:0]                       dest_mac,
  input  logic [31:0]                       oq_reg_out,
  input  logic [47:0]                       mac0,
  input  logic [47:0]                       mac1,
  input  logic [47:0]                       mac2,
  input  logic [47:0]                       mac3,
  output logic [31:0]                       forwarded_count,
  output logic [31:0]                       arp_miss_count,
  output logic [31:0]                       ttl_expired_count,
  output logic                              res_overflow
);

  localparam int RES_DEPTH = 1 << RES_DEPTH_BITS;
  localparam int RES_W     = 57;
  localparam logic [RES_DEPTH_BITS:0] PTR_ONE = {{RES_DEPTH_BITS{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RES  = 3'd1,
    ST_HEAD_OUT  = 3'd2,
    ST_HEAD_PASS = 3'd3,
    ST_BODY      = 3'd4
  } state_t;

  state_t                            state_q, state_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    hold_data_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  hold_strb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   hold_user_q;
  logic                              hold_last_q;
  logic [RES_W-1:0]                  res_mem_q [RES_DEPTH];
  logic [RES_DEPTH_BITS:0]           wr_ptr_q, rd_ptr_q;
  logic [31:0]                       fwd_cnt_q, miss_cnt_q, ttl_cnt_q;
  logic                              ovf_q;

  logic                              res_empty_s, res_full_s, push_s, pop_s, load_s;
  logic [RES_W-1:0]                  res_head_s;
  logic                              res_hit_s, ok_s;
  logic [47:0]                       res_mac_s, src_mac_s;
  logic [7:0]                        res_oq_s, ttl_s, redirect_s;
  logic [15:0]                       csum_s, csum_new_s;
  logic [16:0]                       csum_sum_s;
  logic [C_M_AXIS_DATA_WIDTH-1:0]    rw_data_s;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   rw_user_s;
  logic                              unused_s;

  assign unused_s    = ^oq_reg_out[31:8];
  assign res_empty_s = (wr_ptr_q == rd_ptr_q);
  assign res_full_s  = (wr_ptr_q[RES_DEPTH_BITS] != rd_ptr_q[RES_DEPTH_BITS]) &&
                       (wr_ptr_q[RES_DEPTH_BITS-1:0] == rd_ptr_q[RES_DEPTH_BITS-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_s      = arp_done && (!res_full_s || pop_s);
  assign res_head_s  = res_mem_q[rd_ptr_q[RES_DEPTH_BITS-1:0]];

  assign forwarded_count   = fwd_cnt_q;
  assign arp_miss_count    = miss_cnt_q;
  assign ttl_expired_count = ttl_cnt_q;
  assign res_overflow      = ovf_q;

  // Header rewrite of the held beat using the result at the FIFO head
  always_comb begin
    rw_data_s  = hold_data_q;
    rw_user_s  = hold_user_q;
    res_hit_s  = res_head_s[56];
    res_mac_s  = res_head_s[55:8];
    res_oq_s   = res_head_s[7:0];
    ttl_s      = hold_data_q[79:72];
    csum_s     = hold_data_q[63:48];
    csum_sum_s = {1'b0, csum_s} + 17'h00100;
    csum_new_s = csum_sum_s[15:0] + {15'd0, csum_sum_s[16]};
    ok_s       = res_hit_s && (ttl_s > 8'd1);
    case (res_oq_s)
      8'h01:   src_mac_s = mac0;
      8'h04:   src_mac_s = mac1;
      8'h10:   src_mac_s = mac2;
      8'h40:   src_mac_s = mac3;
      default: src_mac_s = mac0;
    endcase
    // CPU port for a physical port is the next bit up; lowest port bit wins.
    casez (hold_user_q[SRC_PORT_POS +: 8])
      8'b???????1: redirect_s = 8'h02;
      8'b?????1?0: redirect_s = 8'h08;
      8'b???1?0?0: redirect_s = 8'h20;
      8'b?1?0?0?0: redirect_s = 8'h80;
      default:     redirect_s = 8'h02;
    endcase
    if (ok_s) begin
      rw_data_s[255:208]           = res_mac_s;
      rw_data_s[207:160]           = src_mac_s;
      rw_data_s[79:72]             = ttl_s - 8'd1;
      rw_data_s[63:48]             = csum_new_s;
      rw_user_s[DST_PORT_POS +: 8] = res_oq_s;
    end else begin
      rw_user_s[DST_PORT_POS +: 8] = redirect_s;
    end
  end

  // Next state, handshakes and output mux
  always_comb begin
    state_d       = state_q;
    load_s        = 1'b0;
    pop_s         = 1'b0;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = hold_data_q;
    M_AXIS_TSTRB  = hold_strb_q;
    M_AXIS_TUSER  = hold_user_q;
    M_AXIS_TLAST  = hold_last_q;
    case (state_q)
      ST_IDLE: begin
        S_AXIS_TREADY = AXI_RESETN;
        if (S_AXIS_TVALID) begin
          load_s = 1'b1;
          if (S_AXIS_TUSER[DST_PORT_POS +: 8] == 8'd0) begin
            state_d = ST_WAIT_RES;
          end else begin
            state_d = ST_HEAD_PASS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RES: begin
        if (!res_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_HEAD_OUT;
        end else begin
          state_d = ST_WAIT_RES;
        end
      end
      ST_HEAD_OUT, ST_HEAD_PASS: begin
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) begin
          state_d = hold_last_q ? ST_IDLE : ST_BODY;
        end else begin
          state_d = state_q;
        end
      end
      ST_BODY: begin
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TSTRB  = S_AXIS_TSTRB;
        M_AXIS_TUSER  = S_AXIS_TUSER;
        M_AXIS_TLAST  = S_AXIS_TLAST;
        M_AXIS_TVALID = S_AXIS_TVALID;
        S_AXIS_TREADY = M_AXIS_TREADY;
        if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BODY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, held head beat, result FIFO and event counters
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_strb_q <= '0;
      hold_user_q <= '0;
      hold_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fwd_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
      ttl_cnt_q   <= 32'd0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        res_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load_s) begin
        hold_data_q <= S_AXIS_TDATA;
        hold_strb_q <= S_AXIS_TSTRB;
        hold_user_q <= S_AXIS_TUSER;
        hold_last_q <= S_AXIS_TLAST;
      end else if (pop_s) begin
        hold_data_q <= rw_data_s;
        hold_user_q <= rw_user_s;
      end
      if (push_s) begin
        res_mem_q[wr_ptr_q[RES_DEPTH_BITS-1:0]] <= {arp_hit, dest_mac, oq_reg_out[7:0]};
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (arp_done && res_full_s && !pop_s) begin
        ovf_q <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        if (ok_s) begin
          fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end else if (!res_hit_s) begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end else begin
          ttl_cnt_q <= ttl_cnt_q + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_hdr_rewrite.sv
// Randomised bench for arp_hdr_rewrite against a packet-level reference model.
module tb_arp_hdr_rewrite;

  localparam int DST = 24;
  localparam int SRC = 16;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;
  typedef struct { int at; logic hit; logic [47:0] mac; logic [7:0] oq; } arp_t;
  typedef struct { logic hit; logic [47:0] mac; logic [7:0] oq; } res_t;

  logic         clk, rst_n;
  logic [255:0] s_data, m_data;
  logic [31:0]  s_strb, m_strb;
  logic [127:0] s_user, m_user;
  logic         s_valid, s_last, s_ready, m_valid, m_last, m_ready;
  logic         arp_done, arp_hit;
  logic [47:0]  dest_mac;
  logic [31:0]  oq_reg_out;
  logic [47:0]  pmac [4];
  logic [31:0]  fwd_cnt, miss_cnt, ttl_cnt;
  logic         ovf;

  arp_hdr_rewrite dut (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n),
    .S_AXIS_TDATA(s_data), .S_AXIS_TSTRB(s_strb), .S_AXIS_TUSER(s_user),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TLAST(s_last), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TDATA(m_data), .M_AXIS_TSTRB(m_strb), .M_AXIS_TUSER(m_user),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TLAST(m_last), .M_AXIS_TREADY(m_ready),
    .arp_done(arp_done), .arp_hit(arp_hit), .dest_mac(dest_mac), .oq_reg_out(oq_reg_out),
    .mac0(pmac[0]), .mac1(pmac[1]), .mac2(pmac[2]), .mac3(pmac[3]),
    .forwarded_count(fwd_cnt), .arp_miss_count(miss_cnt), .ttl_expired_count(ttl_cnt),
    .res_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          rdy_mode = 0;
  beat_t       src_q[$], out_q[$], exp_q[$];
  arp_t        arp_q[$];
  res_t        res_q[$];
  logic [31:0] exp_fwd = 32'd0, exp_miss = 32'd0, exp_ttl = 32'd0;
  logic        exp_ovf = 1'b0;
  beat_t       last_head;
  logic [7:0]  port_tab [6] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02, 8'h00};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample handshakes 1 ns later.
  task automatic tick();
    beat_t b;
    arp_t a;
    logic [31:0] r;
    @(negedge clk);
    if (src_q.size() > 0) begin
      s_valid = 1'b1; s_data = src_q[0].data; s_strb = src_q[0].strb;
      s_user = src_q[0].user; s_last = src_q[0].last;
    end else begin
      s_valid = 1'b0; s_last = 1'b0;
    end
    r = $urandom();
    if (arp_q.size() > 0 && arp_q[0].at <= cycle) begin
      a = arp_q.pop_front();
      arp_done = 1'b1; arp_hit = a.hit; dest_mac = a.mac; oq_reg_out = {r[31:8], a.oq};
    end else begin
      arp_done = 1'b0; arp_hit = r[0]; oq_reg_out = r;
    end
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cycle % 2 == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (s_valid && s_ready) b = src_q.pop_front();
    if (m_valid && m_ready) begin
      b.data = m_data; b.strb = m_strb; b.user = m_user; b.last = m_last;
      out_q.push_back(b);
    end
    cycle++;
  endtask

  // Reference: forwarding decision and header edits at packet level.
  task automatic model_head(inout beat_t b);
    res_t r;
    int ttl, cs, sel, src, dst;
    r   = res_q.pop_front();
    ttl = int'(b.data[79:72]);
    cs  = int'(b.data[63:48]);
    if (r.hit && ttl > 1) begin
      sel = 0;
      for (int k = 0; k < 4; k++) if (int'(r.oq) == (1 << (2 * k))) sel = k;
      b.data[255:208] = r.mac;
      b.data[207:160] = pmac[sel];
      b.data[79:72]   = 8'(ttl - 1);
      cs = cs + 256;
      if (cs > 65535) cs = cs - 65535;
      b.data[63:48]   = 16'(cs);
      b.user[DST +: 8] = r.oq;
      exp_fwd++;
    end else begin
      src = int'(b.user[SRC +: 8]);
      dst = 2;
      for (int k = 0; k < 4; k++) if (src == (1 << (2 * k))) dst = 1 << (2 * k + 1);
      b.user[DST +: 8] = 8'(dst);
      if (!r.hit) exp_miss++;
      else exp_ttl++;
    end
  endtask

  task automatic sched_arp(input int delay, input logic hit, input logic [47:0] mac, input logic [7:0] oq);
    int at;
    res_t r;
    at = cycle + delay;
    if (arp_q.size() > 0 && at <= arp_q[$].at) at = arp_q[$].at + 1;
    arp_q.push_back('{at, hit, mac, oq});
    r = '{hit, mac, oq};
    if (res_q.size() < 4) res_q.push_back(r);
    else exp_ovf = 1'b1;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] dst, input logic [7:0] src,
                          input logic [7:0] ttl, input logic [15:0] cs);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 8; w++) b.data[w*32 +: 32] = $urandom();
      for (int w = 0; w < 4; w++) b.user[w*32 +: 32] = $urandom();
      b.strb = $urandom();
      b.last = (i == n - 1);
      if (i == 0) begin
        b.data[79:72] = ttl; b.data[63:48] = cs;
        b.user[DST +: 8] = dst; b.user[SRC +: 8] = src;
      end
      src_q.push_back(b);
      if (i == 0 && dst == 8'd0) model_head(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic run(output int used);
    used = 0;
    while (!(src_q.size() == 0 && arp_q.size() == 0 && out_q.size() >= exp_q.size()) && used < 300) begin
      tick();
      used++;
    end
    check("timeout", 256'(used < 300), 256'd1);
    repeat (3) tick();
  endtask

  task automatic compare(input string tag);
    beat_t o, e;
    logic first;
    first = 1'b1;
    check({tag, ".nbeats"}, 256'(out_q.size()), 256'(exp_q.size()));
    while (out_q.size() > 0 && exp_q.size() > 0) begin
      o = out_q.pop_front();
      e = exp_q.pop_front();
      if (first) last_head = o;
      first = o.last;
      check({tag, ".data"}, o.data, e.data);
      check({tag, ".strb"}, 256'(o.strb), 256'(e.strb));
      check({tag, ".user"}, 256'(o.user), 256'(e.user));
      check({tag, ".last"}, 256'(o.last), 256'(e.last));
    end
    out_q.delete();
    exp_q.delete();
    check({tag, ".fwd"}, 256'(fwd_cnt), 256'(exp_fwd));
    check({tag, ".miss"}, 256'(miss_cnt), 256'(exp_miss));
    check({tag, ".ttl"}, 256'(ttl_cnt), 256'(exp_ttl));
    check({tag, ".ovf"}, 256'(ovf), 256'(exp_ovf));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int used, n;
    logic routed;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0; s_user = '0; s_last = 1'b0;
    m_ready = 1'b1; arp_done = 1'b0; arp_hit = 1'b0; dest_mac = '0; oq_reg_out = '0;
    for (int k = 0; k < 4; k++) pmac[k] = {16'($urandom()), 32'($urandom())};
    repeat (3) @(negedge clk);
    #1;
    check("rst.m_valid", 256'(m_valid), 256'd0);
    check("rst.s_ready", 256'(s_ready), 256'd0);
    check("rst.fwd", 256'(fwd_cnt), 256'd0);
    check("rst.ovf", 256'(ovf), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sched_arp(3, 1'b1, 48'h001122334455, 8'h04);
    send_pkt(1, 8'h00, 8'h01, 8'd64, 16'hB1E6);
    run(used);
    compare("t1");
    check("t1.dmac", 256'(last_head.data[255:208]), 256'h001122334455);
    check("t1.smac", 256'(last_head.data[207:160]), 256'(pmac[1]));
    check("t1.ttl", 256'(last_head.data[79:72]), 256'd63);
    check("t1.csum", 256'(last_head.data[63:48]), 256'hB2E6);
    check("t1.dst", 256'(last_head.user[DST +: 8]), 256'h04);
    check("t1.fwd1", 256'(fwd_cnt), 256'd1);

    sched_arp(0, 1'b1, 48'hA0B0C0D0E0F0, 8'h10);
    send_pkt(1, 8'h00, 8'h04, 8'd20, 16'hFF80);
    run(used);
    compare("t2");
    check("t2.csum", 256'(last_head.data[63:48]), 256'h0081);

    sched_arp(1, 1'b0, 48'h0, 8'h01);
    send_pkt(2, 8'h00, 8'h10, 8'd64, 16'h1234);
    run(used);
    compare("t3miss");
    check("t3.dst", 256'(last_head.user[DST +: 8]), 256'h20);
    check("t3.miss1", 256'(miss_cnt), 256'd1);
    sched_arp(2, 1'b1, 48'h0, 8'h04);
    send_pkt(1, 8'h00, 8'h10, 8'd1, 16'h4321);
    run(used);
    compare("t3ttl");
    check("t3.dst2", 256'(last_head.user[DST +: 8]), 256'h20);
    check("t3.ttl1", 256'(ttl_cnt), 256'd1);

    send_pkt(3, 8'h40, 8'h01, 8'd9, 16'h5555);
    run(used);
    check("t4.latency", 256'(used <= 4), 256'd1);
    compare("t4pass");
    check("t4.dst", 256'(last_head.user[DST +: 8]), 256'h40);
    sched_arp(0, 1'b1, 48'h111111111111, 8'h01);
    sched_arp(0, 1'b1, 48'h222222222222, 8'h40);
    repeat (4) tick();
    send_pkt(1, 8'h00, 8'h01, 8'd30, 16'h0F0F);
    send_pkt(2, 8'h00, 8'h04, 8'd31, 16'hF0F0);
    run(used);
    compare("t4order");

    for (int p = 0; p < 24; p++) begin
      rdy_mode = $urandom_range(0, 2);
      routed = 1'($urandom_range(0, 3) != 0);
      n = $urandom_range(1, 4);
      if (routed) sched_arp($urandom_range(0, 5), 1'($urandom_range(0, 3) != 0),
                            {16'($urandom()), 32'($urandom())}, port_tab[$urandom_range(0, 5)]);
      send_pkt(n, routed ? 8'h00 : port_tab[$urandom_range(0, 4)], port_tab[$urandom_range(0, 5)],
               ($urandom_range(0, 3) != 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? 16'($urandom()) : {8'hFF, 8'($urandom())});
      run(used);
      compare("rand");
    end

    rdy_mode = 1;
    sched_arp(2, 1'b1, 48'h0A0B0C0D0E0F, 8'h10);
    send_pkt(4, 8'h00, 8'h40, 8'd100, 16'h8000);
    run(used);
    compare("t5bp");
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) sched_arp(i, 1'b1, 48'h0, 8'h01);
    run(used);
    check("t5.ovf0", 256'(ovf), 256'd0);
    sched_arp(0, 1'b1, 48'h0, 8'h01);
    run(used);
    check("t5.ovf1", 256'(ovf), 256'd1);
    compare("t5ovf");

    send_pkt(4, 8'h40, 8'h04, 8'd50, 16'h1111);
    used = 0;
    while (out_q.size() < 2 && used < 50) begin
      tick();
      used++;
    end
    check("t6.reach_body", 256'(used < 50), 256'd1);
    rst_n = 1'b0;
    #1;
    check("t6.m_valid", 256'(m_valid), 256'd0);
    check("t6.fwd", 256'(fwd_cnt), 256'd0);
    check("t6.miss", 256'(miss_cnt), 256'd0);
    check("t6.ovf", 256'(ovf), 256'd0);
    src_q.delete(); out_q.delete(); exp_q.delete(); arp_q.delete(); res_q.delete();
    exp_fwd = 32'd0; exp_miss = 32'd0; exp_ttl = 32'd0; exp_ovf = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sched_arp(1, 1'b1, 48'hCAFEBABE0001, 8'h40);
    send_pkt(2, 8'h00, 8'h04, 8'd8, 16'hABCD);
    run(used);
    compare("t6post");
    check("t6.fwd1", 256'(fwd_cnt), 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
